game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow controller for the sliding-puzzle VGA board. It sequences clear, grid, level-splash, play, number-redraw and game-over phases for the drawing datapath. It supports NUM_LEVELS difficulty levels and per-phase cycle budgets with an early-finish handshake from the drawer. It also counts moves and enforces an optional move limit, which is the lose condition.

Parameters:
NUM_LEVELS, 3, number of selectable difficulty levels (width of go)
DRAW_CYCLES, 3216, maximum cycles spent in GRID, DRAW_LVL and NUM phases
CLEAR_CYCLES, 16080, cycles spent in CLEAR phase (no early exit)
MAX_MOVES, 0, move limit causing loss; 0 disables the limit
MOVE_W, 10, width of move_count
LVL_W, 2, width of level_idx; must satisfy 2**LVL_W >= NUM_LEVELS

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
go  in  NUM_LEVELS  level-select/any-key buttons, level-sensitive, already synchronised
move_valid  in  1  one-cycle pulse per legal tile move from the board logic
win  in  1  board solved (level)
draw_done  in  1  drawer finished the current phase (pulse)
clear  out  1  high throughout CLEAR
draw_grid  out  1  high throughout GRID
draw_level  out  1  high throughout DRAW_LVL
draw_num  out  1  high throughout NUM
in_game  out  1  high in PLAY and NUM
game_over  out  1  high in OVER
won  out  1  in OVER: 1 = win, 0 = move-limit loss; held until next CLEAR
draw_start  out  1  one-cycle pulse on the first cycle of CLEAR, GRID, DRAW_LVL, NUM
level_idx  out  LVL_W  latched selected level index
move_count  out  MOVE_W  moves made in current game, saturating

Behaviour:
- All outputs are registered Moore outputs decoded from the state register.
- Asynchronous reset enters CLEAR: timer=0, move_count=0, level_idx=0, won=0, arm=0, draw_start=1 on the first cycle after release; all other outputs are per-state.
- Timer: counts cycles in the current state, clears on every state change, and saturates at its maximum.
- CLEAR: exit to GRID when timer==CLEAR_CYCLES-1; draw_done is ignored.
- GRID: exit to SELECT on draw_done or timer==DRAW_CYCLES-1, whichever comes first.
- SELECT: arm flag clears on entry and sets on any cycle with go==0. When armed and go is exactly one-hot, latch level_idx = index of the set bit and go to DRAW_LVL. Multi-hot or zero go is ignored. This prevents a button held from OVER or abort from auto-selecting a level.
- DRAW_LVL: exit on draw_done or timeout to START.
- START: move_count<=0. Go to PLAY when go==0.
- PLAY priority per cycle, evaluated in this order:
  - win=1 -> OVER with won=1.
  - MAX_MOVES!=0 and move_count>=MAX_MOVES -> OVER with won=0.
  - go!=0 -> CLEAR (abort).
  - move_valid=1 -> move_count+1 (saturating at all-ones) and go to NUM.
- NUM: move_valid and win are ignored. Exit to PLAY requires (draw_done seen or timeout) AND go==0. A draw_done pulse is latched until exit.
- OVER: go!=0 -> CLEAR. won and move_count hold until CLEAR entry; CLEAR clears won.
- A simultaneous win and move_valid in PLAY resolves as a win, and the move is not counted.
- Asserting reset in any state returns immediately to CLEAR with reset values.

Test Plan:
- Reset release, no inputs: clear=1 for 16080 cycles, then draw_grid=1 for 3216 cycles, then SELECT; draw_start pulses at cycle 0 and cycle 16080.
- In GRID, pulse draw_done at cycle 10: SELECT is entered at cycle 11. In SELECT, set go=3'b100 -> level_idx=2 and draw_level=1. Set go=3'b011 instead -> state stays SELECT.
- Hold go=3'b001 from OVER through CLEAR and GRID into SELECT: no selection occurs. Release go, then press 3'b010 -> level_idx=1.
- In PLAY, issue 3 move_valid pulses, each followed by draw_done with go=0: move_count=3 and in_game stays 1 throughout.
- With MAX_MOVES=2, issue two moves: after the second NUM, PLAY goes to OVER with game_over=1 and won=0. Drive win=1 together with move_valid on the first move instead -> won=1, move_count=0.
- Assert resetn=0 mid-NUM: all outputs return to reset values asynchronously, and clear=1 after release.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Board/drawer handshake bundle for game_flow_ctrl.
// The master side drives buttons and drawer/board events; the slave side is the controller.
`timescale 1ns/1ps
interface game_flow_ctrl_if #(
  parameter int NUM_LEVELS = 3,
  parameter int LVL_W      = 2,
  parameter int MOVE_W     = 10
);
  logic [NUM_LEVELS-1:0] go;
  logic                  move_valid;
  logic                  win;
  logic                  draw_done;
  logic                  clear;
  logic                  draw_grid;
  logic                  draw_level;
  logic                  draw_num;
  logic                  in_game;
  logic                  game_over;
  logic                  won;
  logic                  draw_start;
  logic [LVL_W-1:0]      level_idx;
  logic [MOVE_W-1:0]     move_count;

  modport master (
    output go, move_valid, win, draw_done,
    input  clear, draw_grid, draw_level, draw_num, in_game, game_over, won,
           draw_start, level_idx, move_count
  );

  modport slave (
    input  go, move_valid, win, draw_done,
    output clear, draw_grid, draw_level, draw_num, in_game, game_over, won,
           draw_start, level_idx, move_count
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: clear -> grid -> level select -> play/redraw -> game over.
// All outputs are decoded from registered state; the drawer may finish phases early via draw_done.
`timescale 1ns/1ps
module game_flow_ctrl #(
  parameter int NUM_LEVELS   = 3,
  parameter int DRAW_CYCLES  = 3216,
  parameter int CLEAR_CYCLES = 16080,
  parameter int MAX_MOVES    = 0,
  parameter int MOVE_W       = 10,
  parameter int LVL_W        = 2
) (
  input  logic            clk,
  input  logic            resetn,
  game_flow_ctrl_if.slave bus
);
  localparam int TMAX    = (CLEAR_CYCLES > DRAW_CYCLES) ? CLEAR_CYCLES : DRAW_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DRAW_LAST  = TIMER_W'(DRAW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_GRID, S_SELECT, S_DRAW_LVL, S_START, S_PLAY, S_NUM, S_OVER
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [MOVE_W-1:0]   move_count_q, move_count_d;
  logic [LVL_W-1:0]    level_idx_q, level_idx_d;
  logic                won_q, won_d;
  logic                arm_q, arm_d;
  logic                done_seen_q, done_seen_d;
  logic                draw_start_q, draw_start_d;
  logic                go_idle, go_onehot, draw_timeout, limit_hit;
  logic [LVL_W-1:0]    go_idx;

  assign go_idle      = (bus.go == '0);
  assign go_onehot    = $onehot(bus.go);
  // Timer saturates, so once past the budget the timeout stays asserted.
  assign draw_timeout = (timer_q >= DRAW_LAST);
  assign limit_hit    = (MAX_MOVES != 0) && (32'(move_count_q) >= 32'(MAX_MOVES));

  always_comb begin
    go_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (bus.go[i]) go_idx = LVL_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    move_count_d = move_count_q;
    level_idx_d  = level_idx_q;
    won_d        = won_q;
    // A button still held on entry to SELECT must be released before it can pick a level.
    arm_d        = (state_q == S_SELECT) && (arm_q || go_idle);
    done_seen_d  = (state_q == S_NUM) && (done_seen_q || bus.draw_done);

    case (state_q)
      S_CLEAR:    if (timer_q == CLEAR_LAST) state_d = S_GRID;
      S_GRID:     if (bus.draw_done || draw_timeout) state_d = S_SELECT;
      S_SELECT: begin
        if (arm_q && go_onehot) begin
          level_idx_d = go_idx;
          state_d     = S_DRAW_LVL;
        end
      end
      S_DRAW_LVL: if (bus.draw_done || draw_timeout) state_d = S_START;
      S_START: begin
        move_count_d = '0;
        if (go_idle) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.win) begin
          won_d   = 1'b1;
          state_d = S_OVER;
        end else if (limit_hit) begin
          won_d   = 1'b0;
          state_d = S_OVER;
        end else if (!go_idle) begin
          state_d = S_CLEAR;
        end else if (bus.move_valid) begin
          if (move_count_q != '1) move_count_d = move_count_q + 1'b1;
          state_d = S_NUM;
        end
      end
      S_NUM:  if ((done_seen_q || bus.draw_done || draw_timeout) && go_idle) state_d = S_PLAY;
      S_OVER: if (!go_idle) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase

    if (state_d == S_CLEAR) won_d = 1'b0;

    if (state_d != state_q)   timer_d = '0;
    else if (timer_q == '1)   timer_d = timer_q;
    else                      timer_d = timer_q + 1'b1;

    draw_start_d = (state_d != state_q) &&
                   (state_d inside {S_CLEAR, S_GRID, S_DRAW_LVL, S_NUM});
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_CLEAR;
      timer_q      <= '0;
      move_count_q <= '0;
      level_idx_q  <= '0;
      won_q        <= 1'b0;
      arm_q        <= 1'b0;
      done_seen_q  <= 1'b0;
      draw_start_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      move_count_q <= move_count_d;
      level_idx_q  <= level_idx_d;
      won_q        <= won_d;
      arm_q        <= arm_d;
      done_seen_q  <= done_seen_d;
      draw_start_q <= draw_start_d;
    end
  end

  assign bus.clear      = (state_q == S_CLEAR);
  assign bus.draw_grid  = (state_q == S_GRID);
  assign bus.draw_level = (state_q == S_DRAW_LVL);
  assign bus.draw_num   = (state_q == S_NUM);
  assign bus.in_game    = (state_q == S_PLAY) || (state_q == S_NUM);
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.won        = won_q;
  assign bus.draw_start = draw_start_q;
  assign bus.level_idx  = level_idx_q;
  assign bus.move_count = move_count_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench: full-size instance for phase timing, small-budget instance for
// vector table, randomized run against a phase-level model, and async reset.
`timescale 1ns/1ps
module tb_game_flow_ctrl;
  localparam int NL = 3;
  localparam int LW = 2;
  localparam int MW = 10;
  localparam int BC = 20;
  localparam int BD = 12;
  localparam int BM = 2;
  localparam int P_CLEAR = 0, P_GRID = 1, P_SELECT = 2, P_DLVL = 3,
                 P_START = 4, P_PLAY = 5, P_NUM = 6, P_OVER = 7;
  localparam logic [7:0] F_CLEAR = 8'h80, F_GRID = 8'h40, F_LVL = 8'h20, F_NUM = 8'h10,
                         F_ING = 8'h08, F_OVER = 8'h04, F_WON = 8'h02, F_ST = 8'h01;

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.NUM_LEVELS(NL), .LVL_W(LW), .MOVE_W(MW)) bus_a ();
  game_flow_ctrl_if #(.NUM_LEVELS(NL), .LVL_W(LW), .MOVE_W(MW)) bus_b ();

  game_flow_ctrl #(.NUM_LEVELS(NL), .DRAW_CYCLES(3216), .CLEAR_CYCLES(16080),
                   .MAX_MOVES(0), .MOVE_W(MW), .LVL_W(LW))
    dut_a (.clk(clk), .resetn(rst_a_n), .bus(bus_a));

  game_flow_ctrl #(.NUM_LEVELS(NL), .DRAW_CYCLES(BD), .CLEAR_CYCLES(BC),
                   .MAX_MOVES(BM), .MOVE_W(MW), .LVL_W(LW))
    dut_b (.clk(clk), .resetn(rst_b_n), .bus(bus_b));

  logic [7:0] a_flags, b_flags;
  assign a_flags = {bus_a.clear, bus_a.draw_grid, bus_a.draw_level, bus_a.draw_num,
                    bus_a.in_game, bus_a.game_over, bus_a.won, bus_a.draw_start};
  assign b_flags = {bus_b.clear, bus_b.draw_grid, bus_b.draw_level, bus_b.draw_num,
                    bus_b.in_game, bus_b.game_over, bus_b.won, bus_b.draw_start};

  function automatic logic [31:0] pack(input logic [7:0] fl, input logic [1:0] lvl, input logic [9:0] mc);
    return {12'd0, fl, lvl, mc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] g, input logic mv, input logic w, input logic dd);
    bus_a.go = g; bus_a.move_valid = mv; bus_a.win = w; bus_a.draw_done = dd;
  endtask

  task automatic drive_b(input logic [2:0] g, input logic mv, input logic w, input logic dd);
    bus_b.go = g; bus_b.move_valid = mv; bus_b.win = w; bus_b.draw_done = dd;
  endtask

  // Phase-level reference model of the small instance.
  int m_ph, m_t, m_mc, m_lvl;
  bit m_won, m_arm, m_seen, m_start;

  task automatic model_reset();
    m_ph = P_CLEAR; m_t = 0; m_mc = 0; m_lvl = 0;
    m_won = 0; m_arm = 0; m_seen = 0; m_start = 1;
  endtask

  task automatic model_step();
    int nph, idx;
    logic [2:0] g;
    g   = bus_b.go;
    nph = m_ph;
    idx = 0;
    for (int i = 0; i < NL; i++) if (g[i]) idx = i;
    case (m_ph)
      P_CLEAR:  if (m_t == BC - 1) nph = P_GRID;
      P_GRID:   if (bus_b.draw_done || m_t >= BD - 1) nph = P_SELECT;
      P_SELECT: begin
        if (m_arm && $countones(g) == 1) begin m_lvl = idx; nph = P_DLVL; end
        else if (g == 0) m_arm = 1;
      end
      P_DLVL:   if (bus_b.draw_done || m_t >= BD - 1) nph = P_START;
      P_START:  begin m_mc = 0; if (g == 0) nph = P_PLAY; end
      P_PLAY: begin
        if (bus_b.win) begin m_won = 1; nph = P_OVER; end
        else if (BM != 0 && m_mc >= BM) begin m_won = 0; nph = P_OVER; end
        else if (g != 0) nph = P_CLEAR;
        else if (bus_b.move_valid) begin
          if (m_mc < (1 << MW) - 1) m_mc = m_mc + 1;
          nph = P_NUM;
        end
      end
      P_NUM: begin
        if (bus_b.draw_done) m_seen = 1;
        if ((m_seen || m_t >= BD - 1) && g == 0) nph = P_PLAY;
      end
      P_OVER:   if (g != 0) nph = P_CLEAR;
      default: ;
    endcase
    m_start = (nph != m_ph) && (nph == P_CLEAR || nph == P_GRID || nph == P_DLVL || nph == P_NUM);
    if (nph != m_ph) begin
      m_t = 0;
      if (nph == P_CLEAR)  m_won  = 0;
      if (nph == P_SELECT) m_arm  = 0;
      if (nph == P_NUM)    m_seen = 0;
    end else begin
      m_t++;
    end
    m_ph = nph;
  endtask

  function automatic logic [31:0] model_out();
    logic [7:0] fl;
    fl = {m_ph == P_CLEAR, m_ph == P_GRID, m_ph == P_DLVL, m_ph == P_NUM,
          m_ph == P_PLAY || m_ph == P_NUM, m_ph == P_OVER, m_won, m_start};
    return pack(fl, 2'(m_lvl), 10'(m_mc));
  endfunction

  function automatic logic [31:0] a_out();
    return pack(a_flags, bus_a.level_idx, bus_a.move_count);
  endfunction

  function automatic logic [31:0] b_out();
    return pack(b_flags, bus_b.level_idx, bus_b.move_count);
  endfunction

  task automatic rand_b();
    int r;
    logic [2:0] g;
    r = $urandom_range(0, 99);
    if (r < 75)      g = 3'd0;
    else if (r < 90) g = 3'(1 << $urandom_range(0, 2));
    else             g = 3'($urandom_range(1, 7));
    drive_b(g, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
  endtask

  task automatic tick_b(input string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, b_out(), model_out());
  endtask

  typedef struct {
    int         n;
    logic [2:0] go;
    logic       mv, win, dd;
    logic [7:0] fl;
    logic [1:0] lvl;
    logic [9:0] mc;
  } vec_t;

  function automatic vec_t mk(int n, logic [2:0] go, logic mv, logic win, logic dd,
                              logic [7:0] fl, logic [1:0] lvl, logic [9:0] mc);
    vec_t v;
    v.n = n; v.go = go; v.mv = mv; v.win = win; v.dd = dd; v.fl = fl; v.lvl = lvl; v.mc = mc;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int clear_cnt, grid_cnt, grid_first, start_cnt, start_ok, drops, found;

    // Small instance walk: CLEAR=20, DRAW=12, MAX_MOVES=2.
    vecs.push_back(mk(19, 3'b000, 0, 0, 0, F_CLEAR,        0, 0));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, F_GRID | F_ST,  0, 0));
    vecs.push_back(mk(10, 3'b000, 0, 0, 0, F_GRID,         0, 0));
    vecs.push_back(mk(1,  3'b000, 0, 0, 1, 8'h00,          0, 0));
    vecs.push_back(mk(1,  3'b011, 0, 0, 0, 8'h00,          0, 0));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, 8'h00,          0, 0));
    vecs.push_back(mk(1,  3'b011, 0, 0, 0, 8'h00,          0, 0));
    vecs.push_back(mk(1,  3'b100, 0, 0, 0, F_LVL | F_ST,   2, 0));
    vecs.push_back(mk(1,  3'b000, 0, 0, 1, 8'h00,          2, 0));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, F_ING,          2, 0));
    vecs.push_back(mk(1,  3'b000, 1, 0, 0, F_NUM | F_ING | F_ST, 2, 1));
    vecs.push_back(mk(1,  3'b000, 0, 0, 1, F_ING,          2, 1));
    vecs.push_back(mk(1,  3'b000, 1, 0, 0, F_NUM | F_ING | F_ST, 2, 2));
    vecs.push_back(mk(1,  3'b001, 0, 0, 1, F_NUM | F_ING,  2, 2));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, F_ING,          2, 2));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, F_OVER,         2, 2));
    vecs.push_back(mk(1,  3'b001, 0, 0, 0, F_CLEAR | F_ST, 2, 2));
    vecs.push_back(mk(20, 3'b001, 0, 0, 0, F_GRID | F_ST,  2, 2));
    vecs.push_back(mk(12, 3'b001, 0, 0, 0, 8'h00,          2, 2));
    vecs.push_back(mk(5,  3'b001, 0, 0, 0, 8'h00,          2, 2));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, 8'h00,          2, 2));
    vecs.push_back(mk(1,  3'b010, 0, 0, 0, F_LVL | F_ST,   1, 2));
    vecs.push_back(mk(12, 3'b000, 0, 0, 0, 8'h00,          1, 2));
    vecs.push_back(mk(1,  3'b000, 0, 0, 0, F_ING,          1, 0));
    vecs.push_back(mk(1,  3'b000, 1, 1, 0, F_OVER | F_WON, 1, 0));
    vecs.push_back(mk(1,  3'b100, 0, 0, 0, F_CLEAR | F_ST, 1, 0));

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive_a(3'b000, 0, 0, 0);
    drive_b(3'b000, 0, 0, 0);
    #12;
    check("reset_a", a_out(), pack(F_CLEAR | F_ST, 0, 0));
    check("reset_b", b_out(), pack(F_CLEAR | F_ST, 0, 0));

    // Full-size phase timing from reset release.
    @(negedge clk);
    rst_a_n = 1'b1;
    clear_cnt = 0; grid_cnt = 0; grid_first = -1; start_cnt = 0; start_ok = 0;
    for (int k = 0; k <= 19296; k++) begin
      if (bus_a.clear) clear_cnt++;
      if (bus_a.draw_grid) begin
        grid_cnt++;
        if (grid_first < 0) grid_first = k;
      end
      if (bus_a.draw_start) begin
        start_cnt++;
        if (k == 0 || k == 16080) start_ok++;
      end
      if (k < 19296) tick();
    end
    check("a_clear_cycles", clear_cnt, 16080);
    check("a_grid_first", grid_first, 16080);
    check("a_grid_cycles", grid_cnt, 3216);
    check("a_start_pulses", start_cnt, 2);
    check("a_start_positions", start_ok, 2);
    check("a_select_idle", a_out(), pack(8'h00, 0, 0));

    drive_a(3'b000, 0, 0, 0); tick();
    drive_a(3'b100, 0, 0, 0); tick();
    check("a_select_lvl2", a_out(), pack(F_LVL | F_ST, 2, 0));
    drive_a(3'b000, 0, 0, 1); tick();
    check("a_start", a_out(), pack(8'h00, 2, 0));
    drive_a(3'b000, 0, 0, 0); tick();
    check("a_play", a_out(), pack(F_ING, 2, 0));
    drops = 0;
    for (int i = 0; i < 3; i++) begin
      drive_a(3'b000, 1, 0, 0); tick();
      if (!bus_a.in_game || !bus_a.draw_num) drops++;
      drive_a(3'b000, 0, 0, 1); tick();
      if (!bus_a.in_game || bus_a.draw_num) drops++;
    end
    drive_a(3'b000, 0, 0, 0);
    check("a_in_game_drops", drops, 0);
    check("a_three_moves", a_out(), pack(F_ING, 2, 3));
    drive_a(3'b001, 0, 0, 0); tick();
    check("a_abort", a_out(), pack(F_CLEAR | F_ST, 2, 3));
    drive_a(3'b000, 0, 0, 0);

    // Vector table on the small instance.
    @(negedge clk);
    rst_b_n = 1'b1;
    foreach (vecs[i]) begin
      drive_b(vecs[i].go, vecs[i].mv, vecs[i].win, vecs[i].dd);
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d", i), b_out(), pack(vecs[i].fl, vecs[i].lvl, vecs[i].mc));
    end
    drive_b(3'b000, 0, 0, 0);

    // Randomized run against the model.
    #2;
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    model_reset();
    check("rand_reset", b_out(), model_out());
    for (int i = 0; i < 4000; i++) begin
      rand_b();
      tick_b("rand");
    end

    // Async reset while redrawing a number.
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      rand_b();
      tick_b("seek_num");
      if (m_ph == P_NUM) found = 1;
    end
    check("reach_num", found, 1);
    #2;
    rst_b_n = 1'b0;
    #1;
    check("async_reset_num", b_out(), pack(F_CLEAR | F_ST, 0, 0));
    drive_b(3'b000, 0, 0, 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    model_reset();
    #1;
    check("after_release", b_out(), pack(F_CLEAR | F_ST, 0, 0));
    tick_b("after_release_edge");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
